// File: rtl/flag_map.sv
// rtl/flag_map.sv - per-cell flag storage with toggle updates, flag count, clear sweep and pixel lookup
module flag_map #(
   parameter int GRID_W    = 16,
   parameter int GRID_H    = 16,
   parameter int CELL_W    = 40,
   parameter int CELL_H    = 30,
   parameter int MAX_FLAGS = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_req,
   input  logic       toggle_req,
   input  logic [5:0] toggle_x,
   input  logic [5:0] toggle_y,
   input  logic       cell_revealed,
   output logic       toggle_ready,
   output logic       toggle_done,
   output logic [1:0] toggle_result,
   output logic [8:0] flag_count,
   output logic       busy,
   input  logic [9:0] xPixel,
   input  logic [9:0] yPixel,
   input  logic       active_pixels,
   output logic       flag_here
);

   localparam int N  = GRID_W * GRID_H;
   localparam int AW = $clog2(N);

   localparam logic [1:0] RES_PLACED   = 2'd0;
   localparam logic [1:0] RES_REMOVED  = 2'd1;
   localparam logic [1:0] RES_REVEALED = 2'd2;
   localparam logic [1:0] RES_LIMIT    = 2'd3;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t          state;
   logic [AW-1:0]   sweep_addr;
   logic            mem [N];

   logic            tgl_in_range;
   logic [AW-1:0]   tgl_addr;
   logic            tgl_bit;
   logic            tgl_accept;
   logic [1:0]      tgl_res;
   logic            tgl_write;

   logic            we;
   logic [AW-1:0]   wa;
   logic            wd;

   logic [9:0]      x_cell;
   logic [9:0]      y_cell;
   logic [9:0]      local_x;
   logic [9:0]      local_y;
   logic            pix_qual;
   logic [AW-1:0]   pix_addr;

   // Toggle decode: the read is combinational from the array, so a write
   // committed on the previous edge is already visible (same-cell bypass).
   always_comb begin
      tgl_in_range = (32'(toggle_x) < GRID_W) && (32'(toggle_y) < GRID_H);
      tgl_addr     = AW'(32'(toggle_y) * 32'(GRID_W) + 32'(toggle_x));
      tgl_bit      = tgl_in_range ? mem[tgl_addr] : 1'b0;
      tgl_accept   = !rst && (state == IDLE) && toggle_req && toggle_ready && !clear_req;
      tgl_res      = RES_PLACED;
      if (!tgl_in_range)
         tgl_res = RES_LIMIT;
      else if (tgl_bit)
         tgl_res = RES_REMOVED;
      else if (cell_revealed)
         tgl_res = RES_REVEALED;
      else if (flag_count == 9'(MAX_FLAGS))
         tgl_res = RES_LIMIT;
      tgl_write = tgl_accept && ((tgl_res == RES_PLACED) || (tgl_res == RES_REMOVED));
   end

   // Single write port shared by the clear sweep and accepted toggles.
   always_comb begin
      we = 1'b0;
      wa = sweep_addr;
      wd = 1'b0;
      if (!rst) begin
         if (state == CLEAR) begin
            we = 1'b1;
         end else if (tgl_write) begin
            we = 1'b1;
            wa = tgl_addr;
            wd = (tgl_res == RES_PLACED);
         end
      end
   end

   // Flag array write, no reset: the sweep is what clears it.
   always_ff @(posedge clk) begin
      if (we)
         mem[wa] <= wd;
   end

   // Control FSM with registered status outputs and flag counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= CLEAR;
         sweep_addr    <= '0;
         flag_count    <= '0;
         toggle_done   <= 1'b0;
         toggle_result <= 2'd0;
         busy          <= 1'b1;
         toggle_ready  <= 1'b0;
      end else begin
         toggle_done <= 1'b0;
         case (state)
            CLEAR: begin
               flag_count <= '0;
               if (sweep_addr == AW'(N - 1)) begin
                  state        <= IDLE;
                  sweep_addr   <= '0;
                  busy         <= 1'b0;
                  toggle_ready <= 1'b1;
               end else begin
                  sweep_addr <= sweep_addr + 1'b1;
               end
            end
            IDLE: begin
               if (clear_req) begin
                  state        <= CLEAR;
                  sweep_addr   <= '0;
                  flag_count   <= '0;
                  busy         <= 1'b1;
                  toggle_ready <= 1'b0;
               end else if (tgl_accept) begin
                  toggle_done   <= 1'b1;
                  toggle_result <= tgl_res;
                  if (tgl_res == RES_PLACED)
                     flag_count <= flag_count + 1'b1;
                  else if (tgl_res == RES_REMOVED)
                     flag_count <= flag_count - 1'b1;
               end
            end
         endcase
      end
   end

   // Pixel to cell mapping; grid lines (local offset 0) are excluded.
   always_comb begin
      x_cell   = 10'(xPixel / 10'(CELL_W));
      y_cell   = 10'(yPixel / 10'(CELL_H));
      local_x  = 10'(xPixel % 10'(CELL_W));
      local_y  = 10'(yPixel % 10'(CELL_H));
      pix_qual = active_pixels && (32'(x_cell) < GRID_W) && (32'(y_cell) < GRID_H) &&
                 (local_x != 10'd0) && (local_y != 10'd0);
      pix_addr = AW'(32'(y_cell) * 32'(GRID_W) + 32'(x_cell));
   end

   // Registered lookup; reads the pre-write value when a toggle hits the same cell.
   always_ff @(posedge clk) begin
      if (rst)
         flag_here <= 1'b0;
      else
         flag_here <= (state == IDLE) && pix_qual && mem[pix_addr];
   end

endmodule

// File: tb/tb_flag_map.sv
// tb/tb_flag_map.sv - scoreboard bench for flag_map
module tb_flag_map;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear_req;
   logic       toggle_req;
   logic [5:0] toggle_x;
   logic [5:0] toggle_y;
   logic       cell_revealed;
   logic       toggle_ready;
   logic       toggle_done;
   logic [1:0] toggle_result;
   logic [8:0] flag_count;
   logic       busy;
   logic [9:0] xPixel;
   logic [9:0] yPixel;
   logic       active_pixels;
   logic       flag_here;

   typedef struct packed {
      logic [1:0] res;
      logic [8:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mflag [256];
   int   mcnt  = 0;

   flag_map dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .toggle_req(toggle_req),
      .toggle_x(toggle_x), .toggle_y(toggle_y), .cell_revealed(cell_revealed),
      .toggle_ready(toggle_ready), .toggle_done(toggle_done), .toggle_result(toggle_result),
      .flag_count(flag_count), .busy(busy), .xPixel(xPixel), .yPixel(yPixel),
      .active_pixels(active_pixels), .flag_here(flag_here)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [1:0] model_toggle(input int x, input int y, input bit rev);
      if (x >= 16 || y >= 16) return 2'd3;
      if (mflag[y*16+x]) begin
         mflag[y*16+x] = 1'b0;
         mcnt--;
         return 2'd1;
      end
      if (rev) return 2'd2;
      if (mcnt == 40) return 2'd3;
      mflag[y*16+x] = 1'b1;
      mcnt++;
      return 2'd0;
   endfunction

   function automatic logic model_pix(input int x, input int y, input bit act);
      int cx, cy;
      cx = x / 40;
      cy = y / 30;
      if (!act || cx >= 16 || cy >= 16 || (x % 40) == 0 || (y % 30) == 0) return 1'b0;
      return mflag[cy*16+cx];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 256; i++) mflag[i] = 1'b0;
      mcnt = 0;
   endtask

   // Scoreboard: every toggle_done consumes one queued expectation.
   always @(negedge clk) begin
      if (toggle_done === 1'b1) begin
         exp_t e;
         chk("done_in_clear", 32'(busy), 0);
         chk("done_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("toggle_result", 32'(toggle_result), 32'(e.res));
            chk("flag_count", 32'(flag_count), 32'(e.cnt));
         end
      end
   end

   task automatic toggle(input int x, input int y, input bit rev);
      exp_t e;
      e.res = model_toggle(x, y, rev);
      e.cnt = 9'(mcnt);
      exp_q.push_back(e);
      toggle_x      = 6'(x);
      toggle_y      = 6'(y);
      cell_revealed = rev;
      toggle_req    = 1'b1;
      @(posedge clk); #1;
      toggle_req    = 1'b0;
      cell_revealed = 1'b0;
      @(negedge clk); #1;
      chk("done_latency", 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   task automatic pix(input string tag, input int x, input int y, input bit act);
      xPixel        = 10'(x);
      yPixel        = 10'(y);
      active_pixels = act;
      @(posedge clk); #1;
      chk(tag, 32'(flag_here), 32'(model_pix(x, y, act)));
      active_pixels = 1'b0;
   endtask

   task automatic sweep_wait(input string tag);
      int n;
      n = 0;
      while (busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, 32'(n), 256);
      chk({tag, "_ready"}, 32'(toggle_ready), 1);
   endtask

   task automatic scan_zero(input string tag);
      int hits;
      hits = 0;
      for (int cy = 0; cy < 16; cy++) begin
         for (int cx = 0; cx < 16; cx++) begin
            xPixel        = 10'(cx * 40 + 20);
            yPixel        = 10'(cy * 30 + 15);
            active_pixels = 1'b1;
            @(posedge clk); #1;
            if (flag_here !== 1'b0) hits++;
         end
      end
      active_pixels = 1'b0;
      chk(tag, 32'(hits), 0);
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; clear_req = 1'b0; toggle_req = 1'b0;
      toggle_x = '0; toggle_y = '0; cell_revealed = 1'b0;
      xPixel = '0; yPixel = '0; active_pixels = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 1);
      chk("rst_ready", 32'(toggle_ready), 0);
      chk("rst_count", 32'(flag_count), 0);
      chk("rst_done", 32'(toggle_done), 0);
      chk("rst_result", 32'(toggle_result), 0);
      chk("rst_flag_here", 32'(flag_here), 0);

      rst = 1'b0;
      sweep_wait("init_sweep");
      chk("init_count", 32'(flag_count), 0);
      scan_zero("init_scan");

      toggle(3, 5, 1'b0);
      pix("pix_flag", 130, 160, 1'b1);
      pix("pix_gridline", 120, 160, 1'b1);
      pix("pix_inactive", 130, 160, 1'b0);
      pix("pix_neighbour", 170, 160, 1'b1);
      toggle(3, 5, 1'b0);
      pix("pix_removed", 130, 160, 1'b1);
      toggle(4, 4, 1'b1);

      for (int i = 0; i < 40; i++) toggle(i % 16, i / 16, 1'b0);
      chk("count_full", 32'(flag_count), 40);
      toggle(8, 3, 1'b0);
      toggle(0, 0, 1'b0);
      chk("count_after_remove", 32'(flag_count), 39);
      toggle(16, 0, 1'b0);
      toggle(0, 16, 1'b0);
      toggle(1, 2, 1'b1);

      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      model_clear();
      chk("clear_busy", 32'(busy), 1);
      chk("clear_count", 32'(flag_count), 0);
      sweep_wait("clear_sweep");
      scan_zero("clear_scan");

      e.res = model_toggle(2, 2, 1'b0); e.cnt = 9'(mcnt); exp_q.push_back(e);
      e.res = model_toggle(2, 2, 1'b0); e.cnt = 9'(mcnt); exp_q.push_back(e);
      toggle_x = 6'd2; toggle_y = 6'd2; toggle_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      toggle_req = 1'b0;
      @(negedge clk); #1;
      chk("b2b_drained", 32'(exp_q.size()), 0);
      exp_q.delete();
      chk("b2b_count", 32'(flag_count), 0);

      toggle(6, 6, 1'b0);
      clear_req = 1'b1; toggle_req = 1'b1; toggle_x = 6'd5; toggle_y = 6'd5;
      @(posedge clk); #1;
      clear_req = 1'b0; toggle_req = 1'b0;
      model_clear();
      chk("simul_busy", 32'(busy), 1);
      sweep_wait("simul_sweep");
      chk("simul_count", 32'(flag_count), 0);
      pix("simul_pix55", 5 * 40 + 20, 5 * 30 + 15, 1'b1);
      pix("simul_pix66", 6 * 40 + 20, 6 * 30 + 15, 1'b1);

      toggle(7, 7, 1'b0);
      toggle(1, 9, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      sweep_wait("mid_sweep");
      chk("mid_count", 32'(flag_count), 0);
      scan_zero("mid_scan");
      toggle(7, 7, 1'b0);

      @(negedge clk); #1;
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flag_map.md
Name: flag_map

Overview:
- Storage and update side of the per-cell flag bit consumed by the flag renderer.
- Holds one flag bit per board cell and accepts place/remove toggle requests from the game controller.
- Maintains a running flag count and a hardware clear sweep.
- Serves a registered per-pixel lookup (flag_here) from the VGA pixel coordinates, already masked to cell interiors.

Parameters:
- GRID_W, 16, board width in cells
- GRID_H, 16, board height in cells
- CELL_W, 40, cell width in pixels
- CELL_H, 30, cell height in pixels
- MAX_FLAGS, 40, maximum simultaneous flags (equals mine count)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- clear_req  in  1  pulse; request clear of all flags
- toggle_req  in  1  request to toggle flag at (toggle_x, toggle_y)
- toggle_x  in  6  target cell column
- toggle_y  in  6  target cell row
- cell_revealed  in  1  target cell already revealed; sampled with toggle_req
- toggle_ready  out  1  high when a toggle is accepted this cycle
- toggle_done  out  1  one-cycle pulse, cycle after acceptance
- toggle_result  out  2  valid with toggle_done: 0 placed, 1 removed, 2 rejected-revealed, 3 rejected-limit/range
- flag_count  out  9  current number of set flags
- busy  out  1  clear sweep in progress
- xPixel  in  10  current pixel column
- yPixel  in  10  current pixel row
- active_pixels  in  1  pixel in visible area
- flag_here  out  1  registered: flag set at this pixel's cell interior

Behaviour:
- Storage: GRID_W*GRID_H bits, address = y*GRID_W + x. One write port, one read port, RAM-inferable; no per-bit reset.
- FSM states: CLEAR, IDLE.
- rst (any state) -> CLEAR; sweep address 0. Reset values: flag_count=0, toggle_done=0, toggle_result=0, flag_here=0, busy=1, toggle_ready=0.
- CLEAR:
  - Writes 0 to one address per cycle, ascending.
  - After address GRID_W*GRID_H-1 is written -> IDLE. Sweep is exactly GRID_W*GRID_H cycles.
  - busy=1, toggle_ready=0, flag_here forced 0, flag_count held 0.
  - clear_req and toggle_req are ignored (not queued).
- IDLE:
  - busy=0, toggle_ready=1.
  - clear_req -> CLEAR at next edge, flag_count<=0. clear_req has priority over a simultaneous toggle_req; the toggle is dropped with no toggle_done.
  - Accepted toggle (toggle_req & toggle_ready) -> toggle_done=1 next cycle, with toggle_result, in this priority order:
    - toggle_x>=GRID_W or toggle_y>=GRID_H: result 3, no write.
    - Bit set: clear bit, flag_count-1, result 1. Removal is allowed even if cell_revealed.
    - cell_revealed: result 2, no write.
    - flag_count==MAX_FLAGS: result 3, no write.
    - Otherwise: set bit, flag_count+1, result 0.
  - Back-to-back requests are accepted every cycle. The read-modify-write of the same cell on consecutive cycles must see the previous write; bypass required.
- flag_count never exceeds MAX_FLAGS and never underflows.
- Pixel lookup:
  - xCell = xPixel / CELL_W, yCell = yPixel / CELL_H.
  - local_x = xPixel % CELL_W, local_y = yPixel % CELL_H.
  - Qualified when active_pixels, xCell<GRID_W, yCell<GRID_H, local_x!=0 and local_y!=0.
  - flag_here = registered(qualified & bit[yCell*GRID_W+xCell]); latency exactly 1 clk from pixel inputs.
  - Simultaneous toggle write to the looked-up cell: lookup returns the pre-write value.
- toggle_done/toggle_result: toggle_result holds its value until the next toggle_done; toggle_done is never high in CLEAR.
- Reset asserted mid-sweep or mid-toggle restarts the sweep at address 0; any pending toggle_done is suppressed.

Test Plan:
- Release rst, wait 256 cycles -> busy=1 exactly 256 cycles, then toggle_ready=1, flag_count=0, flag_here=0 for every pixel of one frame.
- Toggle (3,5) unrevealed -> toggle_done next cycle, result 0, flag_count 1. Drive xPixel=130, yPixel=160, active=1 -> flag_here=1 one cycle later. At xPixel=120 (grid line) -> 0. With active=0 -> 0.
- Toggle (3,5) again -> result 1, count 0. Toggle (4,4) with cell_revealed=1 -> result 2, count unchanged.
- Place 40 distinct flags, then a 41st -> result 3, count stays 40. Remove one -> count 39. Toggle (16,0) -> result 3.
- Toggle (2,2) on two consecutive cycles -> results 0 then 1, count ends 0. Same-cycle clear_req+toggle_req -> no toggle_done, busy for 256 cycles, count 0.
- Assert rst at sweep address 100 -> sweep restarts, busy lasts 256 cycles after release, all flags read 0.
